// File: rtl/io_periph_bank.sv
`default_nettype none
// ============================================================================
//  Module   : io_periph_bank
//  Brief    : Memory-mapped LED/LCD/HEX/switch peripheral bank with a
//             valid/ready request-response port, byte-masked writes and a
//             switch synchroniser/debouncer. Define PERIPH_IRQ_EN to add the
//             switch-change interrupt (IRQ_STATUS W1C at 0x204, IRQ_MASK at 0x208).
//  Revision : 1.0 - initial release
// ============================================================================
module io_periph_bank #(
    parameter int NUM_HEX         = 8,
    parameter int NUM_SW          = 32,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ADDR_W          = 12
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [ADDR_W-1:0]      req_addr_i,
    input  logic [31:0]            req_wdata_i,
    input  logic [3:0]             req_bmask_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [31:0]            rsp_rdata_o,
    output logic                   rsp_err_o,
    input  logic [NUM_SW-1:0]      io_sw_i,
    output logic [31:0]            io_ledr_o,
    output logic [31:0]            io_ledg_o,
    output logic [31:0]            io_lcd_o,
    output logic [NUM_HEX*32-1:0]  io_hex_o,
    output logic                   irq_o
);

    localparam int                CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [ADDR_W-1:0] ADDR_LEDR = ADDR_W'(32'h000);
    localparam logic [ADDR_W-1:0] ADDR_LEDG = ADDR_W'(32'h010);
    localparam logic [ADDR_W-1:0] ADDR_LCD  = ADDR_W'(32'h080);
    localparam logic [ADDR_W-1:0] ADDR_SW   = ADDR_W'(32'h200);
`ifdef PERIPH_IRQ_EN
    localparam logic [ADDR_W-1:0] ADDR_STAT = ADDR_W'(32'h204);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(32'h208);
`endif

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  bm);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = bm[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return r;
    endfunction

    logic [31:0]              ledr_q, ledr_d, ledg_q, ledg_d, lcd_q, lcd_d;
    logic [NUM_HEX-1:0][31:0] hex_q, hex_d;
    logic                     rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [31:0]              rsp_rdata_q, rsp_rdata_d;
    logic [NUM_SW-1:0]        sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NUM_SW-1:0]        cand_q, cand_d, deb_q, deb_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d, run;
    logic                     req_fire, wr_en, hit, acc_err;
    logic                     sel_ledr, sel_ledg, sel_lcd, sel_sw;
    logic [NUM_HEX-1:0]       sel_hex;
    logic [31:0]              sw_ext, rd_mux;
`ifdef PERIPH_IRQ_EN
    logic [NUM_SW-1:0]        stat_q, stat_d, mask_q, mask_d, w1c;
    logic [31:0]              stat_ext, mask_ext, wr_masked, mask_merged;
    logic                     irq_q, irq_d, sel_stat, sel_mask;
`endif

    assign req_ready_o = !rsp_valid_q || rsp_ready_i;
    assign req_fire    = req_valid_i && req_ready_o;

    // All mapped addresses are word aligned, so a misaligned address simply misses every select.
    always_comb begin
        sel_ledr = (req_addr_i == ADDR_LEDR);
        sel_ledg = (req_addr_i == ADDR_LEDG);
        sel_lcd  = (req_addr_i == ADDR_LCD);
        sel_sw   = (req_addr_i == ADDR_SW);
        for (int i = 0; i < NUM_HEX; i++) begin
            sel_hex[i] = (req_addr_i == ADDR_W'(32'h100 + 32'(4 * i)));
        end
        sw_ext                = '0;
        sw_ext[NUM_SW-1:0]    = deb_q;
        hit = sel_ledr || sel_ledg || sel_lcd || sel_sw || (|sel_hex);
        rd_mux = '0;
        if (sel_ledr) rd_mux = ledr_q;
        if (sel_ledg) rd_mux = ledg_q;
        if (sel_lcd)  rd_mux = lcd_q;
        if (sel_sw)   rd_mux = sw_ext;
        for (int i = 0; i < NUM_HEX; i++) begin
            if (sel_hex[i]) rd_mux = hex_q[i];
        end
`ifdef PERIPH_IRQ_EN
        sel_stat              = (req_addr_i == ADDR_STAT);
        sel_mask              = (req_addr_i == ADDR_MASK);
        stat_ext              = '0;
        stat_ext[NUM_SW-1:0]  = stat_q;
        mask_ext              = '0;
        mask_ext[NUM_SW-1:0]  = mask_q;
        hit = hit || sel_stat || sel_mask;
        if (sel_stat) rd_mux = stat_ext;
        if (sel_mask) rd_mux = mask_ext;
`endif
        acc_err = (req_addr_i[1:0] != 2'b00) || !hit || (req_we_i && sel_sw);
        wr_en   = req_fire && req_we_i && !acc_err;
    end

    // Run length of the synced value saturates at DEBOUNCE_CYCLES; debounced value follows once reached.
    always_comb begin
        sync1_d = io_sw_i;
        sync2_d = sync1_q;
        cand_d  = sync2_q;
        if (sync2_q != cand_q) begin
            run = CNT_W'(1);
        end else if (cnt_q == CNT_MAX) begin
            run = CNT_MAX;
        end else begin
            run = cnt_q + 1'b1;
        end
        cnt_d = run;
        deb_d = (run >= CNT_MAX) ? sync2_q : deb_q;
    end

    always_comb begin
        ledr_d = ledr_q;
        ledg_d = ledg_q;
        lcd_d  = lcd_q;
        hex_d  = hex_q;
        if (wr_en) begin
            if (sel_ledr) ledr_d = byte_merge(ledr_q, req_wdata_i, req_bmask_i);
            if (sel_ledg) ledg_d = byte_merge(ledg_q, req_wdata_i, req_bmask_i);
            if (sel_lcd)  lcd_d  = byte_merge(lcd_q,  req_wdata_i, req_bmask_i);
            for (int i = 0; i < NUM_HEX; i++) begin
                if (sel_hex[i]) hex_d[i] = byte_merge(hex_q[i], req_wdata_i, req_bmask_i);
            end
        end
    end

`ifdef PERIPH_IRQ_EN
    // A new change event wins over a simultaneous write-one-to-clear on the same bit.
    always_comb begin
        wr_masked   = byte_merge(32'h0, req_wdata_i, req_bmask_i);
        mask_merged = byte_merge(mask_ext, req_wdata_i, req_bmask_i);
        w1c         = (wr_en && sel_stat) ? wr_masked[NUM_SW-1:0] : '0;
        stat_d      = (stat_q & ~w1c) | (deb_d ^ deb_q);
        mask_d      = (wr_en && sel_mask) ? mask_merged[NUM_SW-1:0] : mask_q;
        irq_d       = |(stat_q & mask_q);
    end
    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    always_comb begin
        rsp_valid_d = rsp_valid_q && !rsp_ready_i;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (req_fire) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            rsp_rdata_d = (req_we_i || acc_err) ? 32'h0 : rd_mux;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ledr_q      <= '0;
            ledg_q      <= '0;
            lcd_q       <= '0;
            hex_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            cand_q      <= '0;
            cnt_q       <= '0;
            deb_q       <= '0;
`ifdef PERIPH_IRQ_EN
            stat_q      <= '0;
            mask_q      <= '0;
            irq_q       <= 1'b0;
`endif
        end else begin
            ledr_q      <= ledr_d;
            ledg_q      <= ledg_d;
            lcd_q       <= lcd_d;
            hex_q       <= hex_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            deb_q       <= deb_d;
`ifdef PERIPH_IRQ_EN
            stat_q      <= stat_d;
            mask_q      <= mask_d;
            irq_q       <= irq_d;
`endif
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign io_ledr_o   = ledr_q;
    assign io_ledg_o   = ledg_q;
    assign io_lcd_o    = lcd_q;
    assign io_hex_o    = hex_q;

endmodule
`default_nettype wire

// File: tb/tb_io_periph_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_io_periph_bank
//  Brief    : Random + directed bench for io_periph_bank against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_io_periph_bank;
    localparam int NH = 8;
    localparam int D  = 16;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0, io_sw = '0;
    logic [3:0]  req_bmask = '0;
    logic        req_ready_o, rsp_valid_o, rsp_err_o, irq_o;
    logic [31:0] rsp_rdata_o, io_ledr_o, io_ledg_o, io_lcd_o;
    logic [NH*32-1:0] io_hex_o;

    int n_cmp = 0, n_bad = 0;

    io_periph_bank #(.NUM_HEX(NH), .NUM_SW(32), .DEBOUNCE_CYCLES(D), .ADDR_W(12)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_bmask_i(req_bmask),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .io_sw_i(io_sw), .io_ledr_o(io_ledr_o), .io_ledg_o(io_ledg_o),
        .io_lcd_o(io_lcd_o), .io_hex_o(io_hex_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_ledr, m_ledg, m_lcd, m_deb, m_rdata, m_stat, m_mask;
    logic [31:0] m_hex [NH];
    bit          m_rv, m_err, m_irq;
    logic [31:0] raw_hist [$];
    logic [31:0] win [$];

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] bm);
        logic [31:0] m = {{8{bm[3]}}, {8{bm[2]}}, {8{bm[1]}}, {8{bm[0]}}};
        return (o & ~m) | (n & m);
    endfunction

    task automatic model_reset();
        m_ledr = 0; m_ledg = 0; m_lcd = 0; m_deb = 0; m_rdata = 0; m_stat = 0; m_mask = 0;
        foreach (m_hex[i]) m_hex[i] = 0;
        m_rv = 0; m_err = 0; m_irq = 0;
        raw_hist = {32'h0, 32'h0};
        win.delete();
    endtask

    task automatic model_step();
        bit fire, er, same, irq_n;
        logic [31:0] a, rd, syn, new_deb, w1c;
        fire  = req_valid && (!m_rv || rsp_ready);
        a     = 32'(req_addr);
        irq_n = |(m_stat & m_mask);
        // synced value seen at this edge is the raw input sampled two edges earlier
        raw_hist.push_back(io_sw);
        syn = raw_hist[raw_hist.size() - 3];
        if (raw_hist.size() > 3) void'(raw_hist.pop_front());
        win.push_back(syn);
        if (win.size() > D) void'(win.pop_front());
        new_deb = m_deb;
        if (win.size() == D) begin
            same = 1;
            foreach (win[k]) if (win[k] != syn) same = 0;
            if (same) new_deb = syn;
        end
        rd = 0; er = 0; w1c = 0;
        if (fire) begin
            if (a % 4 != 0) er = 1;
            else if (a == 32'h000) rd = m_ledr;
            else if (a == 32'h010) rd = m_ledg;
            else if (a == 32'h080) rd = m_lcd;
            else if (a >= 32'h100 && a < 32'h100 + 4 * NH) rd = m_hex[(a - 32'h100) / 4];
            else if (a == 32'h200) begin if (req_we) er = 1; else rd = m_deb; end
`ifdef PERIPH_IRQ_EN
            else if (a == 32'h204) rd = m_stat;
            else if (a == 32'h208) rd = m_mask;
`endif
            else er = 1;
            if (req_we && !er) begin
                if (a == 32'h000) m_ledr = merge(m_ledr, req_wdata, req_bmask);
                if (a == 32'h010) m_ledg = merge(m_ledg, req_wdata, req_bmask);
                if (a == 32'h080) m_lcd  = merge(m_lcd,  req_wdata, req_bmask);
                if (a >= 32'h100 && a < 32'h100 + 4 * NH)
                    m_hex[(a - 32'h100) / 4] = merge(m_hex[(a - 32'h100) / 4], req_wdata, req_bmask);
                if (a == 32'h204) w1c = merge(32'h0, req_wdata, req_bmask);
                if (a == 32'h208) m_mask = merge(m_mask, req_wdata, req_bmask);
            end
            m_rv = 1; m_err = er; m_rdata = (req_we || er) ? 32'h0 : rd;
        end else if (rsp_ready) begin
            m_rv = 0;
        end
`ifdef PERIPH_IRQ_EN
        m_stat = (m_stat & ~w1c) | (new_deb ^ m_deb);
        m_irq  = irq_n;
`endif
        m_deb = new_deb;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        logic [NH*32-1:0] hx;
        #1;
        if (!rst) begin
            foreach (m_hex[i]) hx[32*i +: 32] = m_hex[i];
            chk("req_ready", req_ready_o, !m_rv || rsp_ready);
            chk("rsp_valid", rsp_valid_o, m_rv);
            if (m_rv) begin
                chk("rsp_rdata", rsp_rdata_o, m_rdata);
                chk("rsp_err", rsp_err_o, m_err);
            end
            chk("ledr", io_ledr_o, m_ledr);
            chk("ledg", io_ledg_o, m_ledg);
            chk("lcd", io_lcd_o, m_lcd);
            chk("hex", io_hex_o, hx);
            chk("irq", irq_o, m_irq);
        end
    end

    // ---------------- stimulus ----------------
    task automatic xact(input bit we, input logic [11:0] addr, input logic [31:0] wd,
                        input logic [3:0] bm, output logic [31:0] rd, output logic er);
        int n;
        @(negedge clk);
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd; req_bmask = bm;
        #1; n = 0;
        while (!req_ready_o && n < 64) begin @(negedge clk); #1; n++; end
        if (n >= 64) begin n_cmp++; n_bad++; $display("FAIL xact_accept_timeout addr %0h", addr); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        #1; n = 0;
        while (!rsp_valid_o && n < 64) begin @(negedge clk); #1; n++; end
        if (n >= 64) begin n_cmp++; n_bad++; $display("FAIL xact_rsp_timeout addr %0h", addr); end
        rd = rsp_rdata_o; er = rsp_err_o;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          glitch_left;
        logic [31:0] sw_saved;
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        chk("reset_ledr", io_ledr_o, 0);
        chk("reset_hex", io_hex_o, 0);
        chk("reset_rsp_valid", rsp_valid_o, 0);
        chk("reset_irq", irq_o, 0);

        // register write/readback and byte masking
        xact(1, 12'h000, 32'h12345678, 4'hF, rd, er);
        xact(1, 12'h010, 32'hA5A5A5A5, 4'hF, rd, er);
        xact(0, 12'h000, 0, 0, rd, er);
        chk("ledr_rd", rd, 32'h12345678);
        xact(1, 12'h10C, 32'hDEADBEEF, 4'b0101, rd, er);
        chk("hex3_out", io_hex_o[127:96], 32'h00AD00EF);
        chk("hex3_err", er, 0);
        xact(1, 12'h080, 32'hFFFFFFFF, 4'b0000, rd, er);
        chk("bmask0_err", er, 0);
        chk("bmask0_lcd", io_lcd_o, 0);

        // error accesses leave state untouched
        xact(0, 12'h0FC, 0, 0, rd, er);
        chk("err_0fc", {er, rd}, {1'b1, 32'h0});
        xact(0, 12'h102, 0, 0, rd, er);
        chk("err_102", {er, rd}, {1'b1, 32'h0});
        xact(1, 12'h200, 32'hFFFFFFFF, 4'hF, rd, er);
        chk("err_wr_sw", {er, rd}, {1'b1, 32'h0});
        xact(0, 12'h000, 0, 0, rd, er);
        chk("ledr_after_err", rd, 32'h12345678);

        // backpressure: response held, no new acceptance
        @(negedge clk);
        rsp_ready = 0;
        xact(0, 12'h000, 0, 0, rd, er);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("bp_ready", req_ready_o, 0);
            chk("bp_rdata", rsp_rdata_o, 32'h12345678);
        end
        @(negedge clk);
        rsp_ready = 1; req_valid = 1; req_we = 0; req_addr = 12'h010;
        #1;
        chk("bp_release_ready", req_ready_o, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        #1;
        chk("bp_next_rdata", rsp_rdata_o, 32'hA5A5A5A5);

        // asynchronous reset with a read response pending
        @(negedge clk);
        rsp_ready = 0;
        @(negedge clk);
        req_valid = 1; req_we = 0; req_addr = 12'h000;
        @(posedge clk);
        #2;
        chk("pre_reset_valid", rsp_valid_o, 1);
        #1 rst = 1;
        #1;
        chk("async_rsp_valid", rsp_valid_o, 0);
        chk("async_ledr", io_ledr_o, 0);
        chk("async_ledg", io_ledg_o, 0);
        chk("async_hex", io_hex_o, 0);
        @(negedge clk);
        rst = 0; req_valid = 0; rsp_ready = 1;
        xact(0, 12'h000, 0, 0, rd, er);
        chk("ledr_after_reset", rd, 0);

        // debounce: slow to appear, short glitch filtered
        @(negedge clk);
        io_sw = 32'h5;
        repeat (6) @(negedge clk);
        xact(0, 12'h200, 0, 0, rd, er);
        chk("sw_early", rd, 0);
        repeat (20) @(negedge clk);
        xact(0, 12'h200, 0, 0, rd, er);
        chk("sw_settled", rd, 32'h5);
        @(negedge clk);
        io_sw = 32'hD;
        repeat (3) @(negedge clk);
        io_sw = 32'h5;
        repeat (30) @(negedge clk);
        xact(0, 12'h200, 0, 0, rd, er);
        chk("sw_glitch", rd, 32'h5);

        // interrupt behaviour
        xact(1, 12'h208, 32'h1, 4'h1, rd, er);
        @(negedge clk);
        io_sw = 32'h4;
        repeat (D + 6) @(negedge clk);
`ifdef PERIPH_IRQ_EN
        chk("irq_set", irq_o, 1);
        xact(1, 12'h204, 32'h1, 4'h1, rd, er);
        @(negedge clk); #1;
        chk("irq_cleared", irq_o, 0);
        @(negedge clk);
        io_sw = 32'h5;
        repeat (D + 1) @(negedge clk);
        req_valid = 1; req_we = 1; req_addr = 12'h204; req_wdata = 32'h1; req_bmask = 4'h1;
        @(negedge clk);
        req_valid = 0;
        xact(0, 12'h204, 0, 0, rd, er);
        chk("set_wins_status", rd[0], 1);
        chk("set_wins_irq", irq_o, 1);
`else
        chk("noirq_pin", irq_o, 0);
        xact(0, 12'h204, 0, 0, rd, er);
        chk("noirq_204_err", er, 1);
        xact(1, 12'h208, 32'h1, 4'hF, rd, er);
        chk("noirq_208_err", er, 1);
`endif

        // randomized traffic
        glitch_left = 0;
        sw_saved = io_sw;
        for (int c = 0; c < 1500; c++) begin
            logic [11:0] addrs [12];
            @(negedge clk);
            addrs = '{12'h000, 12'h010, 12'h080, 12'h100 + 12'(4 * $urandom_range(0, NH - 1)),
                      12'h200, 12'h204, 12'h208, 12'h0FC, 12'h102, 12'h120, 12'h011,
                      12'($urandom & 32'h3FF)};
            req_valid = ($urandom_range(0, 1) == 1);
            req_we    = ($urandom_range(0, 1) == 1);
            req_addr  = addrs[$urandom_range(0, 11)];
            req_wdata = $urandom;
            req_bmask = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (glitch_left > 0) begin
                glitch_left--;
                if (glitch_left == 0) io_sw = sw_saved;
            end else if ($urandom_range(0, 24) == 0) begin
                io_sw = $urandom; sw_saved = io_sw;
            end else if ($urandom_range(0, 39) == 0) begin
                sw_saved = io_sw; io_sw = $urandom; glitch_left = $urandom_range(1, D - 1);
            end
        end
        @(negedge clk);
        req_valid = 0; rsp_ready = 1;
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
